// File: rtl/tx_scheduler.sv
// Ethernet TX scheduler: arbitrates reset/state/keepalive packet requests into a
// single transmitter with start/done handshake, done timeout and inter-frame gap.
module tx_scheduler #(
  parameter int IFG_CYCLES       = 48,
  parameter int TIMEOUT_CYCLES   = 4096,
  parameter int KEEPALIVE_CYCLES = 1000000
) (
  input  logic        eth_clk,
  input  logic        eth_rstn,
  input  logic        frame_tick,
  input  logic [33:0] state_data,
  input  logic        rst_req,
  input  logic        tx_busy,
  input  logic        tx_done,
  output logic        tx_start,
  output logic [1:0]  tx_type,
  output logic [33:0] tx_payload,
  output logic [2:0]  pend,
  output logic        tx_err,
  output logic [7:0]  drop_cnt
);

  localparam int CW = $clog2((TIMEOUT_CYCLES > IFG_CYCLES ? TIMEOUT_CYCLES : IFG_CYCLES) + 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] IFG_LAST = CW'(IFG_CYCLES - 1);
  localparam logic [19:0]   KA_LAST  = 20'(KEEPALIVE_CYCLES - 1);

  localparam logic [1:0] T_STATE = 2'b00;
  localparam logic [1:0] T_RESET = 2'b01;
  localparam logic [1:0] T_KA    = 2'b10;

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  state_t        r_state, w_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [19:0]   r_ka;
  logic [2:0]    r_pend, w_pend_nxt;
  logic [33:0]   r_shadow, r_last;
  logic          r_rst_q;
  logic          r_tx_start;
  logic [1:0]    r_tx_type;
  logic [33:0]   r_tx_payload;
  logic          r_tx_err;
  logic [7:0]    r_drop;

  logic          w_grant, w_err_set, w_rst_rise, w_ka_hit, w_drop;
  logic [1:0]    w_gtype;
  logic [33:0]   w_gpay;

  assign w_rst_rise = rst_req & ~r_rst_q;
  assign w_ka_hit   = ~r_tx_start && (r_ka == KA_LAST);
  // A tick coinciding with a state grant refills the pend bit rather than dropping.
  assign w_drop     = frame_tick && r_pend[1] && !(w_grant && w_gtype == T_STATE);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_grant   = 1'b0;
    w_gtype   = T_STATE;
    w_err_set = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (!tx_busy && r_pend != 3'b000) begin
          w_grant = 1'b1;
          w_nxt   = START;
          if (r_pend[0])      w_gtype = T_RESET;
          else if (r_pend[1]) w_gtype = T_STATE;
          else                w_gtype = T_KA;
        end
      end
      START: begin
        w_cnt_nxt = '0;
        w_nxt     = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tx_done) begin
          w_cnt_nxt = '0;
          w_nxt     = GAP;
        end else if (r_cnt == TO_LAST) begin
          w_cnt_nxt = '0;
          w_err_set = 1'b1;
          w_nxt     = GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      GAP: begin
        if (r_cnt == IFG_LAST) begin
          w_cnt_nxt = '0;
          w_nxt     = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (w_gtype)
      T_RESET: w_gpay = '0;
      T_STATE: w_gpay = r_shadow;
      default: w_gpay = r_last;
    endcase
  end

  // New requests win over the clear of a bit granted in the same cycle.
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_grant) begin
      case (w_gtype)
        T_RESET: w_pend_nxt[0] = 1'b0;
        T_STATE: w_pend_nxt[1] = 1'b0;
        default: w_pend_nxt[2] = 1'b0;
      endcase
    end
    if (w_rst_rise) w_pend_nxt[0] = 1'b1;
    if (frame_tick) w_pend_nxt[1] = 1'b1;
    if (w_ka_hit)   w_pend_nxt[2] = 1'b1;
  end

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_ff @(posedge eth_clk or negedge eth_rstn) begin
    if (!eth_rstn) begin
      r_pend       <= '0;
      r_shadow     <= '0;
      r_last       <= '0;
      r_rst_q      <= 1'b0;
      r_ka         <= '0;
      r_tx_start   <= 1'b0;
      r_tx_type    <= '0;
      r_tx_payload <= '0;
      r_tx_err     <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_pend     <= w_pend_nxt;
      r_rst_q    <= rst_req;
      r_tx_start <= w_grant;
      if (frame_tick) r_shadow <= state_data;
      if (w_grant) begin
        r_tx_type    <= w_gtype;
        r_tx_payload <= w_gpay;
        if (w_gtype == T_STATE) r_last <= r_shadow;
      end
      if (r_tx_start || w_ka_hit) r_ka <= '0;
      else                        r_ka <= r_ka + 1'b1;
      if (w_err_set) r_tx_err <= 1'b1;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 1'b1;
    end
  end

  assign tx_start   = r_tx_start;
  assign tx_type    = r_tx_type;
  assign tx_payload = r_tx_payload;
  assign pend       = r_pend;
  assign tx_err     = r_tx_err;
  assign drop_cnt   = r_drop;

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 Parameter: IFG_CYCLES, 48, idle eth_clk cycles enforced between tx_done and the next grant.
REQ-002 Parameter: TIMEOUT_CYCLES, 4096, maximum WAIT_DONE cycles before abort.
REQ-003 Parameter: KEEPALIVE_CYCLES, 1000000, idle cycles since last tx_start before a keepalive is requested.
REQ-004 Port: eth_clk  in  1  sole clock, 50 MHz ethernet reference.
REQ-005 Port: eth_rstn  in  1  asynchronous, active-low reset.
REQ-006 Port: frame_tick  in  1  one-cycle pulse, already in eth_clk domain: new game state is valid.
REQ-007 Port: state_data  in  34  {x[10:0], y[10:0], dir[8:0], game[2:0]}, sampled on frame_tick.
REQ-008 Port: rst_req  in  1  level request to broadcast a game reset.
REQ-009 Port: tx_busy  in  1  transmitter is not ready to accept a start.
REQ-010 Port: tx_done  in  1  one-cycle pulse: current packet fully sent.
REQ-011 Port: tx_start  out  1  one-cycle start pulse to transmitter.
REQ-012 Port: tx_type  out  2  00 state, 01 reset, 10 keepalive; 11 unused.
REQ-013 Port: tx_payload  out  34  payload for the granted packet.
REQ-014 Port: pend  out  3  pending flags {keepalive, state, reset}.
REQ-015 Port: tx_err  out  1  sticky; set on any timeout.
REQ-016 Port: drop_cnt  out  8  saturating count of overwritten state requests.

Function
REQ-017 FSM states: IDLE, START, WAIT_DONE, GAP; all outputs registered.
REQ-018 frame_tick: copy state_data into the state shadow; set pend[1].
REQ-019 frame_tick while pend[1] already set and not granted that cycle: increment drop_cnt (saturate at 255); shadow takes the newest data.
REQ-020 rst_req rising edge (registered previous value): set pend[0]; a held-high level does not re-request.
REQ-021 Keepalive counter: 20 bits; clears on tx_start; at KEEPALIVE_CYCLES-1 sets pend[2] and clears.
REQ-022 IDLE: when tx_busy=0 and pend != 0, grant with fixed priority reset > state > keepalive, clear that pend bit, latch tx_type/tx_payload, go START.
REQ-023 Payloads: reset = 34'b0; state = shadow; keepalive = last sent state payload (0 after reset).
REQ-024 Grant and frame_tick in the same cycle: grant sends the old shadow; pend[1] stays set for the new data; drop_cnt unchanged.
REQ-025 START: tx_start=1 for exactly this one cycle; go to WAIT_DONE.
REQ-026 tx_type and tx_payload stay stable from START until the next grant.
REQ-027 WAIT_DONE: on tx_done go to GAP.
REQ-028 WAIT_DONE: if tx_done has not arrived after TIMEOUT_CYCLES cycles, set tx_err and go to GAP.
REQ-029 tx_done outside WAIT_DONE is ignored.
REQ-030 GAP: count IFG_CYCLES cycles, then go to IDLE; requests keep accumulating during GAP.
REQ-031 Latency: frame_tick sampled at edge N with the FSM in IDLE and tx_busy=0 gives tx_start high in the cycle after edge N+1.
REQ-032 tx_busy=1 in IDLE blocks the grant indefinitely; no timeout applies in IDLE.

Reset
REQ-033 eth_rstn=0 asynchronously forces:
- state IDLE;
- tx_start, tx_type, tx_payload, pend, tx_err, drop_cnt, shadows, all counters and the rst_req edge register all 0.
REQ-034 Deasserting eth_rstn mid-packet abandons it; no tx_start is issued until a new request arrives.

Verification
REQ-035 Single frame_tick with state_data=34'h2_0040_1234 in idle: tx_start high exactly once, 2 cycles after the tick; tx_type=00; tx_payload=34'h2_0040_1234.
REQ-036 rst_req rises in the same cycle as frame_tick: reset packet first (type 01, payload 0); after tx_done + 48 cycles, the state packet.
REQ-037 Three frame_ticks (data A, B, C) while in WAIT_DONE: drop_cnt=2; the next state packet carries C.
REQ-038 tx_done withheld: tx_err=1 after 4096 WAIT_DONE cycles; FSM returns to IDLE after 48 more cycles; tx_err stays 1 until reset.
REQ-039 No requests for 1000000 cycles after sending payload P: keepalive with type 10 and payload P.
REQ-040 eth_rstn pulsed low during WAIT_DONE with pend=3'b011: all outputs 0 immediately; no tx_start follows without new stimulus.
